ps2_scancode_rx: RTL and testbench
==================================

Name: ps2_scancode_rx

Overview:
- PS/2 keyboard receiver between the MiST I/O controller's ps2_kbd_clk/ps2_kbd_data lines and the KC87 keyboard matrix logic.
- Synchronises and filters both lines into clk_sys, then deframes 11-bit PS/2 frames.
- Folds E0/F0 prefix bytes into flags on the following code.
- Delivers codes through a small FIFO with a valid/ready handshake.

Parameters:
- FILTER_LEN, 8: consecutive stable clk_sys cycles needed before a filtered line changes.
- TIMEOUT_CYC, 100000: cycles with no falling edge mid-frame before abort (2 ms at 50 MHz).
- FIFO_DEPTH, 4: decoded-code FIFO entries; power of two, minimum 2.

Ports:
- clk_sys  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- code  out  8  scancode at FIFO head.
- code_ext  out  1  head code was preceded by E0.
- code_rel  out  1  head code was preceded by F0 (break).
- code_valid  out  1  FIFO not empty.
- code_ready  in  1  consumer accepts head when code_valid & code_ready.
- frame_err  out  1  one-cycle pulse on parity, start or stop error, or timeout.
- overflow  out  1  one-cycle pulse when a code is dropped because the FIFO is full.
- err_count  out  8  saturating error counter (see Optional Feature).

Behaviour:
- Reset:
  - All outputs 0.
  - Filtered lines and both sync flops set to 1.
  - FIFO empty; FSM in IDLE; prefix flags cleared.
- Line conditioning, per line: 2-FF synchroniser, then a stability counter. The filtered output takes the synchronised value after FILTER_LEN equal consecutive samples. Latency from raw input to filtered output is 2+FILTER_LEN cycles.
- Edge: fall = filtered clk was 1 in the previous cycle and is 0 now. filt_data is sampled in the same cycle.
- FSM states and transitions:
  - IDLE: on fall, data=0 goes to DATA with bit count 0; data=1 raises frame_err and stays in IDLE.
  - DATA: 8 falls, shifted in LSB first, then go to PARITY.
  - PARITY: on fall, check odd parity (ones in data plus parity bit must be odd). On mismatch, latch an error flag and continue to STOP.
  - STOP: on fall, data must be 1 and the error flag clear. Otherwise raise frame_err. Return to IDLE in either case.
- Timeout: in any non-IDLE state, a timeout counter resets on every fall. When it reaches TIMEOUT_CYC-1: go to IDLE, pulse frame_err, clear prefix flags.
- Any frame_err also clears the prefix flags.
- Good frame, byte B:
  - B=E0: set ext flag; nothing pushed.
  - B=F0: set rel flag; nothing pushed.
  - Any other B (E1 included): push {ext,rel,B} and clear both flags.
- Latency: stop-bit fall at cycle T; code_valid and head outputs valid at T+1.
- FIFO:
  - pop = code_valid & code_ready.
  - Push while full with no pop: entry dropped, overflow pulses, prefix flags still cleared.
  - Push and pop in the same cycle while full: both happen, count unchanged.
  - Push and pop in the same cycle while empty: push only (code_valid is 0, so no pop).
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
  - Head outputs are stable while code_valid & !code_ready.
- Reset asserted mid-frame: frame discarded, no frame_err, FIFO flushed.

Optional Feature:
- Macro PS2_RX_ERRCNT_EN.
- Defined: err_count increments by 1 on each cycle where frame_err or overflow is high (+1 even if both are high in the same cycle). Saturates at 255; cleared only by reset.
- Undefined: err_count is tied to 0 and no counter logic is generated.

Decomposition:
- Package kc87_ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants PS2_PFX_EXT=8'hE0 and PS2_PFX_REL=8'hF0.
  - Packed struct ps2_code_t {ext, rel, code[7:0]} used as the FIFO entry.
- Sub-module ps2_line_filter (synchroniser plus stability filter, FILTER_LEN parameter), instantiated for clk and data.
- FIFO stays inline.

Test Plan:
- Frame 0x1C, parity 0, stop 1, 12.5 kHz bit clock, code_ready=1 -> exactly one beat code=1C, ext=0, rel=0; frame_err stays 0.
- Frames F0, 1C -> one beat, code=1C, rel=1, ext=0.
- Frames E0, F0, 75 -> one beat, code=75, ext=1, rel=1; a following frame 75 -> ext=0, rel=0.
- Frame 0x1C with parity bit 1 -> single frame_err pulse, no push; next good frame 0x1C is delivered normally.
- Three bits, then lines held high for 2.1 ms -> one frame_err pulse at TIMEOUT_CYC after the last fall, FSM back in IDLE. A pending F0 is cleared, so a following 1C arrives with rel=0.
- code_ready=0, five codes 15,16,17,18,19 -> four stored, overflow pulses once on 19. Raising ready pops 15,16,17,18 in order.
- With PS2_RX_ERRCNT_EN defined -> err_count=2 after the timeout case (F0 then timeout counts as one) plus one overflow; saturation verified.

Source files
------------

// File: rtl/kc87_ps2_pkg.sv
// rtl/kc87_ps2_pkg.sv - shared types and constants for the KC87 PS/2 scancode receiver
package kc87_ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_code_t;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchroniser plus stability filter for one PS/2 line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic line,
    output logic filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Any sample agreeing with the current output restarts the stability window.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            filt  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard deframer with E0/F0 folding and code FIFO
// Optional saturating error counter enabled by macro PS2_RX_ERRCNT_EN.
module ps2_scancode_rx
    import kc87_ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_ext,
    output logic       code_rel,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       frame_err,
    output logic       overflow,
    output logic [7:0] err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic          filt_clk;
    logic          filt_data;
    logic          prev_clk;
    logic          fall;
    ps2_state_e    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          perr;
    logic [TW-1:0] tmo;
    logic          ext_flag;
    logic          rel_flag;

    ps2_code_t     mem [FIFO_DEPTH];
    ps2_code_t     head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic stop_done, frame_good, push, pop, full, do_write;
    logic start_err, timeout_hit, err_now;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .line    (ps2_clk),
        .filt    (filt_clk)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .line    (ps2_data),
        .filt    (filt_data)
    );

    assign fall        = prev_clk & ~filt_clk;
    assign stop_done   = (state == STOP) && fall;
    assign frame_good  = stop_done && filt_data && !perr;
    assign push        = frame_good && (shreg != PS2_PFX_EXT) && (shreg != PS2_PFX_REL);
    assign start_err   = (state == IDLE) && fall && filt_data;
    assign timeout_hit = (state != IDLE) && !fall && (tmo == TW'(TIMEOUT_CYC - 1));
    assign err_now     = start_err || (stop_done && !frame_good) || timeout_hit;

    assign code_valid  = (count != '0);
    assign full        = (count == CW'(FIFO_DEPTH));
    assign pop         = code_valid && code_ready;
    assign do_write    = push && (!full || pop);

    assign head        = mem[rd_ptr];
    assign code        = head.code;
    assign code_ext    = head.ext;
    assign code_rel    = head.rel;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            tmo       <= '0;
            ext_flag  <= 1'b0;
            rel_flag  <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            prev_clk  <= 1'b1;
        end else begin
            prev_clk  <= filt_clk;
            frame_err <= err_now;
            overflow  <= push && full && !pop;

            if (state == IDLE || fall) begin
                tmo <= '0;
            end else begin
                tmo <= tmo + TW'(1);
            end

            case (state)
                IDLE: begin
                    if (fall && !filt_data) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        perr    <= 1'b0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shreg   <= {filt_data, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall) begin
                        perr  <= ~(^shreg ^ filt_data);
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (timeout_hit) begin
                state <= IDLE;
            end

            // Flags apply to exactly one following code, dropped or not.
            if (err_now || push) begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end else if (frame_good) begin
                if (shreg == PS2_PFX_EXT) ext_flag <= 1'b1;
                if (shreg == PS2_PFX_REL) rel_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= '{ext: ext_flag, rel: rel_flag, code: shreg};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_write && !pop) begin
                count <= count + CW'(1);
            end else if (!do_write && pop) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef PS2_RX_ERRCNT_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            err_count <= '0;
        end else if ((frame_err || overflow) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - randomized self-checking bench for ps2_scancode_rx
module tb_ps2_scancode_rx;

    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int FD   = 4;
    localparam int HALF = 25;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       code_ready = 1'b0;
    logic [7:0] code;
    logic       code_ext, code_rel, code_valid, frame_err, overflow;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [9:0] exp_q[$];
    logic [9:0] pop_log[$];
    bit         m_ext, m_rel;
    int         m_err = 0, m_ovf = 0, m_ecnt = 0;
    int         seen_err = 0, seen_ovf = 0, last_err_cyc = 0;
    bit         rand_ready = 0;
    logic [9:0] prev_head = '0;
    bit         prev_hold = 0;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_ext   (code_ext),
        .code_rel   (code_rel),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    always #10 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc++;

    always @(posedge clk_sys) begin
        if (rand_ready) begin
            #1;
            code_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Per-cycle compare: head of DUT FIFO against the model queue.
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (frame_err) begin
                seen_err++;
                last_err_cyc = cyc;
            end
            if (overflow) seen_ovf++;
            if (code_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_code actual=%0h required=none", {code_ext, code_rel, code});
                end else begin
                    check("head", {code_ext, code_rel, code}, exp_q[0]);
                end
                if (prev_hold) check("head_stable", {code_ext, code_rel, code}, prev_head);
                if (code_ready) begin
                    pop_log.push_back({code_ext, code_rel, code});
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
            prev_hold = code_valid && !code_ready;
            prev_head = {code_ext, code_rel, code};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic model_err();
        m_err++;
        m_ecnt++;
        m_ext = 0;
        m_rel = 0;
    endtask

    task automatic model_good(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_rel = 1;
        else begin
            if (exp_q.size() >= FD) begin
                m_ovf++;
                m_ecnt++;
            end else begin
                exp_q.push_back({m_ext, m_rel, b});
            end
            m_ext = 0;
            m_rel = 0;
        end
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        tick(HALF);
        ps2_clk = 0;
        tick(HALF);
        ps2_clk = 1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit chk_lat = 0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ bad_par);
        ps2_data = !bad_stop;
        tick(HALF);
        ps2_clk = 0;
        if (bad_par || bad_stop) model_err();
        else model_good(b);
        if (chk_lat) begin
            tick(FL + 2);
            check("latency_before", code_valid, 1'b0);
            tick(1);
            check("latency_at", code_valid, 1'b1);
            tick(HALF - FL - 3);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1;
        ps2_data = 1;
        tick(4 * HALF);
    endtask

    task automatic start_pulse();
        ps2_data = 1;
        tick(HALF);
        ps2_clk = 0;
        model_err();
        tick(HALF);
        ps2_clk = 1;
        tick(HALF);
    endtask

    task automatic checkpoint(input string tag);
        tick(40);
        check({tag, "_frame_err_cnt"}, seen_err, m_err);
        check({tag, "_overflow_cnt"}, seen_ovf, m_ovf);
        check({tag, "_valid"}, code_valid, exp_q.size() != 0);
`ifdef PS2_RX_ERRCNT_EN
        check({tag, "_err_count"}, err_count, (m_ecnt > 255) ? 255 : m_ecnt);
`else
        check({tag, "_err_count"}, err_count, 0);
`endif
    endtask

    task automatic expect_pops(input string tag, input int n, input logic [9:0] w0,
                               input logic [9:0] w1 = '0, input logic [9:0] w2 = '0,
                               input logic [9:0] w3 = '0);
        logic [9:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        check({tag, "_pop_n"}, pop_log.size(), n);
        for (int i = 0; i < n && i < pop_log.size(); i++) begin
            check({tag, "_pop"}, pop_log[i], w[i]);
        end
        pop_log.delete();
    endtask

    initial begin
        int r;
        int c_last;
        logic [7:0] b;

        tick(5);
        reset = 0;
        tick(1);
        check("rst_valid", code_valid, 0);
        check("rst_code", {code_ext, code_rel, code}, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_count", err_count, 0);

        code_ready = 1;
        send_frame(8'h1C, 0, 0, 1);
        checkpoint("plain");
        expect_pops("plain", 1, 10'h01C);

        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        checkpoint("break");
        expect_pops("break", 1, 10'h11C);

        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'h75, 0, 0);
        checkpoint("ext_break");
        expect_pops("ext_break", 2, 10'h375, 10'h075);

        send_frame(8'h1C, 1, 0);
        checkpoint("parity");
        check("parity_err_seen", seen_err, 1);
        send_frame(8'h1C, 0, 0);
        checkpoint("after_parity");
        expect_pops("after_parity", 1, 10'h01C);

        start_pulse();
        checkpoint("start_err");

        send_frame(8'hF0, 0, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 0;
        tick(HALF);
        ps2_clk = 0;
        c_last = cyc;
        tick(HALF);
        ps2_clk = 1;
        ps2_data = 1;
        model_err();
        tick(TO + 100);
        check("timeout_latency", last_err_cyc - c_last, TO + FL + 3);
        checkpoint("timeout");
        send_frame(8'h1C, 0, 0);
        checkpoint("after_timeout");
        expect_pops("after_timeout", 1, 10'h01C);

        code_ready = 0;
        for (int i = 0; i < 5; i++) send_frame(8'h15 + 8'(i), 0, 0);
        checkpoint("overflow");
        check("overflow_head", {code_ext, code_rel, code}, 10'h015);
        code_ready = 1;
        tick(10);
        expect_pops("overflow", 4, 10'h015, 10'h016, 10'h017, 10'h018);

        rand_ready = 1;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 99);
            b = 8'($urandom_range(0, 255));
            if (r < 10) send_frame(b, 1, 0);
            else if (r < 15) send_frame(b, 0, 1);
            else if (r < 20) start_pulse();
            else if (r < 35) send_frame(8'hE0, 0, 0);
            else if (r < 50) send_frame(8'hF0, 0, 0);
            else send_frame(b, 0, 0);
        end
        rand_ready = 0;
        tick(2);
        code_ready = 1;
        checkpoint("random");
        pop_log.delete();

        code_ready = 0;
        send_frame(8'h22, 0, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1;
        reset = 1;
        exp_q.delete();
        m_ext = 0;
        m_rel = 0;
        m_ecnt = 0;
        tick(3);
        reset = 0;
        code_ready = 1;
        checkpoint("mid_reset");
        check("mid_reset_valid", code_valid, 0);
        send_frame(8'h1C, 0, 0);
        checkpoint("after_reset");
        expect_pops("after_reset", 1, 10'h01C);

        for (int i = 0; i < 260; i++) start_pulse();
        checkpoint("saturate");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
